// File: rtl/encode_pair.sv
// -----------------------------------------------------------------------------
// encode_pair
//
// One radix-combine step of the sntrup761 encoder. A limb pair
// (r0 mod m0, r1 mod m1) is folded into r = r0 + m0*r1 with modulus
// M = m0*m1. While M >= 2^M0LEN, the low byte of r is emitted and both r and
// M are shifted down by one byte, with M rounded up. What is left is handed
// back as the residual (r, M) for the next combine level.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   pair request handshake; in_ready is high only in IDLE
//   r0, r1, m0, m1        limb pair and moduli, sampled only at the accept cycle
//   out_valid / out_ready byte stream handshake towards the packer
//   out_byte              emitted byte, LSB-first
//   res_valid / res_ready residual handshake towards the scheduler
//   res_r, res_m          residual value and modulus
// -----------------------------------------------------------------------------
module encode_pair #(
   parameter int M0LEN = 14,
   parameter int RLEN  = 2*M0LEN + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [M0LEN-1:0] r0,
   input  logic [M0LEN-1:0] r1,
   input  logic [M0LEN-1:0] m0,
   input  logic [M0LEN-1:0] m1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_byte,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [M0LEN-1:0] res_r,
   output logic [M0LEN-1:0] res_m
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Sampled limb pair; held unchanged until the next accept.
   logic [M0LEN-1:0] r0_q, r1_q, m0_q, m1_q;

   // Working value and modulus, one spare bit so that M+255 cannot overflow.
   logic [RLEN-1:0] r_q, m_q;

   // Zero-extended operands so that the products are formed at full RLEN.
   logic [RLEN-1:0] r0_ext, r1_ext, m0_ext, m1_ext;
   logic [RLEN-1:0] prod_r, prod_m;
   logic [RLEN-1:0] m_sum, r_shift, m_shift;
   logic            calc_big, shift_big;

   logic load, calc, shift;

   // --------------------------------------------------------------------------
   // Datapath arithmetic
   // --------------------------------------------------------------------------
   assign r0_ext = {{(RLEN-M0LEN){1'b0}}, r0_q};
   assign r1_ext = {{(RLEN-M0LEN){1'b0}}, r1_q};
   assign m0_ext = {{(RLEN-M0LEN){1'b0}}, m0_q};
   assign m1_ext = {{(RLEN-M0LEN){1'b0}}, m1_q};

   assign prod_r = r0_ext + m0_ext * r1_ext;
   assign prod_m = m0_ext * m1_ext;

   // Byte shift of r truncates; the modulus rounds up so that r < M is kept.
   assign m_sum   = m_q + RLEN'(255);
   assign r_shift = {8'd0, r_q[RLEN-1:8]};
   assign m_shift = {8'd0, m_sum[RLEN-1:8]};

   // "M >= 2^M0LEN" is simply any bit set at or above position M0LEN.
   assign calc_big  = |prod_m[RLEN-1:M0LEN];
   assign shift_big = |m_shift[RLEN-1:M0LEN];

   assign load  = (state_q == IDLE) && in_valid;
   assign calc  = (state_q == CALC);
   assign shift = (state_q == EMIT) && out_ready;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------------
   // NOTE: every datapath register is cleared by reset, so an aborted pair
   // leaves nothing behind that could leak onto out_byte or the residual.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0_q <= '0;
         r1_q <= '0;
         m0_q <= '0;
         m1_q <= '0;
         r_q  <= '0;
         m_q  <= '0;
      end else begin
         if (load) begin
            r0_q <= r0;
            r1_q <= r1;
            m0_q <= m0;
            m1_q <= m1;
         end
         if (calc) begin
            r_q <= prod_r;
            m_q <= prod_m;
         end else if (shift) begin
            r_q <= r_shift;
            m_q <= m_shift;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output decode
   // --------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_byte  = 8'd0;
      res_valid = 1'b0;
      res_r     = '0;
      res_m     = '0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = CALC;
            end
         end

         CALC: begin
            state_d = calc_big ? EMIT : DONE;
         end

         EMIT: begin
            out_valid = 1'b1;
            out_byte  = r_q[7:0];
            if (out_ready) begin
               state_d = shift_big ? EMIT : DONE;
            end
         end

         DONE: begin
            res_valid = 1'b1;
            res_r     = r_q[M0LEN-1:0];
            res_m     = m_q[M0LEN-1:0];
            // Returning to IDLE first means in_ready rises only the cycle
            // after the residual handshake.
            if (res_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_encode_pair.sv
// -----------------------------------------------------------------------------
// tb_encode_pair
//
// Directed bench for encode_pair. Inputs are driven and outputs sampled on the
// falling clock edge, so every check lands half a cycle away from the edge
// that updates the design. Each pair is followed cycle by cycle, so the
// accept -> CALC -> byte -> residual latency is checked exactly.
// -----------------------------------------------------------------------------
module tb_encode_pair;

   localparam int M0LEN = 14;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [M0LEN-1:0] r0, r1, m0, m1;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_byte;
   logic             res_valid;
   logic             res_ready;
   logic [M0LEN-1:0] res_r, res_m;

   int compared   = 0;
   int mismatched = 0;

   encode_pair #(.M0LEN(M0LEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .r0        (r0),
      .r1        (r1),
      .m0        (m0),
      .m1        (m1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_r     (res_r),
      .res_m     (res_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                tag, observed, observed, expected, expected);
      end
   endtask

   // Runs one pair through the block with optional stalls on each byte and on
   // the residual. Expected bytes and residual are hand-computed constants.
   task automatic run_pair(input string tag,
                           input logic [M0LEN-1:0] a0, a1, b0, b1,
                           input int nb,
                           input logic [7:0] byte0, byte1,
                           input logic [M0LEN-1:0] exp_r, exp_m,
                           input int out_stall, input int res_stall);
      logic [7:0] exp_byte;

      // Accept cycle (edge T).
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      r0 = a0; r1 = a1; m0 = b0; m1 = b1;

      // CALC cycle (T+1): inputs scrambled to show they are no longer sampled.
      @(negedge clk);
      in_valid = 1'b0;
      r0 = 14'h3FFF; r1 = 14'h2AAA; m0 = 14'h1555; m1 = 14'h0F0F;
      check({tag, " in_ready calc"},  32'(in_ready),  32'd0);
      check({tag, " out_valid calc"}, 32'(out_valid), 32'd0);
      check({tag, " res_valid calc"}, 32'(res_valid), 32'd0);

      for (int k = 0; k < nb; k++) begin
         exp_byte = (k == 0) ? byte0 : byte1;
         @(negedge clk);
         out_ready = (out_stall == 0);
         check($sformatf("%s byte%0d valid", tag, k), 32'(out_valid), 32'd1);
         check($sformatf("%s byte%0d value", tag, k), 32'(out_byte), 32'(exp_byte));
         check($sformatf("%s byte%0d res_valid", tag, k), 32'(res_valid), 32'd0);
         check($sformatf("%s byte%0d in_ready", tag, k), 32'(in_ready), 32'd0);
         for (int s = 0; s < out_stall; s++) begin
            @(negedge clk);
            check($sformatf("%s byte%0d hold valid", tag, k), 32'(out_valid), 32'd1);
            check($sformatf("%s byte%0d hold value", tag, k), 32'(out_byte), 32'(exp_byte));
            check($sformatf("%s byte%0d hold in_ready", tag, k), 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
      end

      // Residual at T+2+k when unstalled.
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " res_valid"},     32'(res_valid), 32'd1);
      check({tag, " res out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " res_r"},         32'(res_r),     32'(exp_r));
      check({tag, " res_m"},         32'(res_m),     32'(exp_m));
      check({tag, " res in_ready"},  32'(in_ready),  32'd0);

      // While the residual is stalled, offer a new pair; it must not be taken.
      for (int s = 0; s < res_stall; s++) begin
         in_valid = 1'b1;
         @(negedge clk);
         check({tag, " res hold valid"},    32'(res_valid), 32'd1);
         check({tag, " res hold r"},        32'(res_r),     32'(exp_r));
         check({tag, " res hold m"},        32'(res_m),     32'(exp_m));
         check({tag, " res hold in_ready"}, 32'(in_ready),  32'd0);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;

      @(negedge clk);
      res_ready = 1'b0;
      check({tag, " after res_valid"}, 32'(res_valid), 32'd0);
      check({tag, " after in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      res_ready = 1'b0;
      r0 = '0; r1 = '0; m0 = '0; m1 = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset res_valid", 32'(res_valid), 32'd0);
      check("reset out_byte",  32'(out_byte),  32'd0);
      check("reset res_r",     32'(res_r),     32'd0);
      check("reset res_m",     32'(res_m),     32'd0);
      rst_n = 1'b1;

      // 35 / 100: no bytes.
      run_pair("c1", 14'd5, 14'd3, 14'd10, 14'd10, 0, 8'h00, 8'h00,
               14'd35, 14'd100, 0, 0);

      // 200100 / 1000000: one byte 0xA4, residual 781 / 3907.
      run_pair("c2", 14'd100, 14'd200, 14'd1000, 14'd1000, 1, 8'hA4, 8'h00,
               14'd781, 14'd3907, 0, 0);

      // 16382*16384 / 16383^2: bytes 0x00, 0x80, residual 4095 / 4096.
      run_pair("c3", 14'd16382, 14'd16382, 14'd16383, 14'd16383, 2, 8'h00, 8'h80,
               14'd4095, 14'd4096, 0, 0);

      // Same as c3 with byte backpressure.
      run_pair("c3s", 14'd16382, 14'd16382, 14'd16383, 14'd16383, 2, 8'h00, 8'h80,
               14'd4095, 14'd4096, 5, 0);

      // Same as c2 with residual backpressure; the next pair follows at once.
      run_pair("c2s", 14'd100, 14'd200, 14'd1000, 14'd1000, 1, 8'hA4, 8'h00,
               14'd781, 14'd3907, 0, 3);
      run_pair("c1b", 14'd5, 14'd3, 14'd10, 14'd10, 0, 8'h00, 8'h00,
               14'd35, 14'd100, 0, 0);

      // Reset while the first byte of c3 is pending.
      @(negedge clk);
      in_valid = 1'b1;
      r0 = 14'd16382; r1 = 14'd16382; m0 = 14'd16383; m1 = 14'd16383;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("rst pending out_valid", 32'(out_valid), 32'd1);
      check("rst pending out_byte",  32'(out_byte),  32'd0);
      rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst res_valid", 32'(res_valid), 32'd0);
      check("rst in_ready",  32'(in_ready),  32'd1);
      check("rst res_r",     32'(res_r),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst release in_ready", 32'(in_ready), 32'd1);
      run_pair("c1r", 14'd5, 14'd3, 14'd10, 14'd10, 0, 8'h00, 8'h00,
               14'd35, 14'd100, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/encode_pair.md
Name: encode_pair

Overview:
- Radix-combine step of the sntrup761 encoder; inverse of the Barrett divide-with-remainder used in decap Decode.
- Accepts one limb pair (r0 mod m0, r1 mod m1) and forms r = r0 + m0*r1 with modulus M = m0*m1.
- Emits low bytes of r while M >= 2^M0LEN, then hands back the residual (r, M) for the next combine level.
- Sits between the per-level pair scheduler and the ciphertext byte packer.

Parameters:
M0LEN, 14, width of limbs and moduli; emission threshold is 2^M0LEN
RLEN, 2*M0LEN+1, internal width of r and M registers (headroom for M+255)

Ports:
clk        input   1      clock, rising edge
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      pair request valid
in_ready   output  1      block can accept a pair
r0         input   M0LEN  low limb, 0 <= r0 < m0
r1         input   M0LEN  high limb, 0 <= r1 < m1
m0         input   M0LEN  modulus of r0, >= 1
m1         input   M0LEN  modulus of r1, >= 1
out_valid  output  1      out_byte valid
out_ready  input   1      packer accepts byte
out_byte   output  8      emitted byte, LSB-first order
res_valid  output  1      residual valid
res_ready  input   1      scheduler accepts residual
res_r      output  M0LEN  residual value
res_m      output  M0LEN  residual modulus

Behaviour:
- Reset:
  - clk and rst_n are a single clock domain; reset is asynchronous and active-low. Asserting rst_n low forces state IDLE and clears all registers.
  - Reset values: out_valid=0, res_valid=0, out_byte=0, res_r=0, res_m=0, in_ready=1 (IDLE decode).
  - Reset mid-operation discards the pair and any pending byte or residual, with no partial output.
- FSM states: IDLE, CALC, EMIT, DONE.
- IDLE:
  - in_ready=1. All other states drive in_ready=0.
  - On in_valid&in_ready, r0, r1, m0 and m1 are registered; next state CALC.
- CALC (exactly 1 cycle):
  - r <= r0 + m0*r1 and M <= m0*m1, both computed at RLEN bits.
  - Next state is EMIT if M >= 2^M0LEN, else DONE.
- EMIT:
  - out_valid=1 and out_byte=r[7:0].
  - On out_ready: r <= r>>8 and M <= (M+255)>>8. Next state is EMIT again if the new M >= 2^M0LEN, else DONE.
  - With out_ready=0, out_byte and all state hold stable. out_valid never drops without a handshake.
- DONE:
  - res_valid=1, res_r=r[M0LEN-1:0], res_m=M[M0LEN-1:0].
  - On res_ready the block returns to IDLE. in_ready rises the following cycle; there is no same-cycle back-to-back accept.
- Latency with no backpressure:
  - Accept at cycle T, CALC at T+1.
  - First byte valid at T+2.
  - res_valid at T+2+k, where k is the number of emitted bytes.
- Byte count: for legal inputs M < 2^28, so k is 0, 1 or 2.
- Residual invariants: res_m is in [1, 2^M0LEN-1] and res_r < res_m.
- out_valid and res_valid are never high in the same cycle.
- Inputs with m0=0, m1=0, r0>=m0 or r1>=m1 are outside contract; no checking is performed.
- Inputs are sampled only at the accept cycle. Changes on r0, r1, m0 and m1 afterwards are ignored.

Test Plan:
- r0=5, r1=3, m0=10, m1=10 -> no bytes; res_valid at T+2 with res_r=35, res_m=100.
- r0=100, r1=200, m0=1000, m1=1000 -> one byte 0xA4 at T+2; then res_r=781, res_m=3907.
- r0=16382, r1=16382, m0=16383, m1=16383 -> bytes 0x00 then 0x80; res_r=4095, res_m=4096.
- Case 3 with out_ready low for 5 cycles on each byte -> out_byte holds 0x00 then 0x80 stably; in_ready stays 0; identical residual.
- Case 2 with res_ready held low for 3 cycles -> res_valid and values hold; in_ready stays 0; a new pair is accepted only after the res handshake.
- Case 3 with rst_n pulsed low while the first byte is pending -> outputs clear immediately, in_ready=1 after release; a following case 1 pair gives res_r=35, res_m=100.
